fifo_pkt_writer: RTL
====================

Name: fifo_pkt_writer

Overview:
- Write-side producer for the team's asynchronous FIFO, in the w_clk domain.
- Accepts a packet request (length) and a valid/ready payload stream from upstream.
- Drives the FIFO write port with one header word followed by the payload words, honouring the FIFO full and almost-full flags.
- Keeps completed-packet count and error status for the control block.

Parameters:
- DATA_W, 8, FIFO word width; must be >= LEN_W.
- LEN_W, 4, width of the packet-length field; max payload = 2^LEN_W - 1 words.
- HOLD_ON_AFULL, 1, 1 = treat fifo_almost_full as a stall, same as full; 0 = ignore almost_full.
- CNT_W, 8, width of the completed-packet counter.

Ports:
- w_clk, input, 1, write-domain clock; all state changes on its rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, packet request; sampled only in IDLE.
- pkt_len, input, LEN_W, payload word count; latched on accepted start.
- s_data, input, DATA_W, upstream payload word.
- s_valid, input, 1, upstream word valid.
- s_ready, output, 1, writer accepts s_data this cycle.
- fifo_full, input, 1, FIFO full flag.
- fifo_almost_full, input, 1, FIFO almost-full flag.
- fifo_din, output, DATA_W, FIFO write data.
- fifo_w_en, output, 1, FIFO write enable.
- busy, output, 1, state != IDLE.
- done, output, 1, one-cycle pulse when a packet finishes.
- start_err, output, 1, sticky error: start seen outside IDLE.
- pkt_count, output, CNT_W, number of completed packets.

Behaviour:
- **Reset** (rst high, asynchronous):
  - state = IDLE, remaining = 0, pkt_count = 0, start_err = 0.
  - All outputs are 0, including fifo_w_en, s_ready, done, busy and fifo_din.
  - Reset mid-packet abandons the packet with no further writes; the FIFO contents are not the writer's concern.
- **stall** = fifo_full | (HOLD_ON_AFULL & fifo_almost_full).
- **States:** IDLE, HDR, PAY, DONE, registered one-hot or binary.
- **IDLE:**
  - start=1 and pkt_len != 0: latch remaining = pkt_len, go to HDR.
  - start=1 and pkt_len == 0: ignored; stay in IDLE, no done, no error.
- **HDR:**
  - fifo_din = pkt_len zero-extended to DATA_W; fifo_w_en = !stall.
  - On a cycle with !stall, go to PAY; otherwise hold in HDR.
- **PAY:**
  - s_ready = !stall; fifo_din = s_data; fifo_w_en = s_valid & s_ready.
  - Each transfer decrements remaining.
  - A transfer with remaining == 1 goes to DONE.
  - s_valid low or stall: hold, no write.
- **DONE:**
  - done = 1 for exactly one cycle; pkt_count increments, wrapping 2^CNT_W-1 -> 0.
  - Next state is IDLE.
- **Combinational outputs:** fifo_w_en, fifo_din and s_ready are combinational from registered state and current inputs.
  - fifo_din = 0 in IDLE and DONE.
  - s_ready = 0 outside PAY.
- **Latency (no stalls):**
  - start accepted at edge 0.
  - Header written during cycle 1; payload words during cycles 2..N+1.
  - done during cycle N+2; IDLE at cycle N+3.
  - A new start is accepted in cycle N+3 at the earliest.
- **start_err:** set when start=1 in HDR, PAY or DONE. That start is otherwise ignored. Cleared only by rst.
- **Write guarantee:** fifo_w_en is never asserted while fifo_full=1, so no write is ever dropped.
- **Simultaneous events:**
  - stall arriving in the same cycle as s_valid means no transfer; the word stays upstream.
  - A start in the DONE cycle sets start_err and is not queued.

Test Plan:
- Basic packet: start, pkt_len=3, s_valid held 1, data 0xA1, 0xA2, 0xA3, no stalls -> fifo_w_en high cycles 1–4 with fifo_din 0x03, 0xA1, 0xA2, 0xA3; done pulses in cycle 5; pkt_count=1; busy high cycles 1–5.
- Full stall: fifo_full=1 during HDR for 4 cycles -> fifo_w_en=0 and state held in HDR; header 0x03 written in the first cycle with full=0; payload then follows unchanged.
- Almost-full throttle:
  - HOLD_ON_AFULL=1, fifo_almost_full=1 mid-payload -> s_ready=0, no writes, remaining unchanged.
  - Same stimulus with HOLD_ON_AFULL=0 -> writes continue.
- Upstream gaps and zero length: pkt_len=15 with s_valid toggling 1/0 -> exactly 15 payload writes with data order preserved. Separately, start with pkt_len=0 -> no writes, no done, busy stays 0.
- Errors: start asserted during PAY -> start_err=1 and stays 1; current packet completes normally; no second packet begins.
- Reset mid-packet and counter wrap:
  - rst pulsed after 2 of 5 payload words -> all outputs 0 immediately, no further writes; the next start of length 1 produces a header plus 1 word.
  - 256 one-word packets -> pkt_count wraps to 0.

Source files
------------

// File: rtl/fifo_pkt_writer_if.sv
// Bundle between the packet writer, its upstream payload source, the control
// block and the asynchronous FIFO write port.
interface fifo_pkt_writer_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 8
) ();
  logic              start;
  logic [LEN_W-1:0]  pkt_len;
  // Payload handshake: a word moves on a rising w_clk edge only when
  // s_valid and s_ready are both high; s_data must stay stable while
  // s_valid is high and s_ready is low.
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              fifo_full;
  logic              fifo_almost_full;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_w_en;
  logic              busy;
  logic              done;
  logic              start_err;
  logic [CNT_W-1:0]  pkt_count;

  // master: the writer itself; slave: upstream, control block and FIFO.
  modport master (
    input  start, pkt_len, s_data, s_valid, fifo_full, fifo_almost_full,
    output s_ready, fifo_din, fifo_w_en, busy, done, start_err, pkt_count
  );
  modport slave (
    output start, pkt_len, s_data, s_valid, fifo_full, fifo_almost_full,
    input  s_ready, fifo_din, fifo_w_en, busy, done, start_err, pkt_count
  );
endinterface

// File: rtl/fifo_pkt_writer.sv
// Write-side packet producer for the async FIFO: one length header word,
// then the payload stream, throttled by the FIFO full/almost-full flags.
module fifo_pkt_writer #(
  parameter int DATA_W        = 8,
  parameter int LEN_W         = 4,
  parameter int HOLD_ON_AFULL = 1,
  parameter int CNT_W         = 8
) (
  input  logic              w_clk,
  input  logic              rst,
  fifo_pkt_writer_if.master bus,
  output logic [1:0]        dbg_state
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  pkt_count_q;
  logic              start_err_q;
  logic              stall;
  logic              xfer;
  logic              w_en;
  logic              rdy;
  logic [DATA_W-1:0] din;

  assign stall = bus.fifo_full | ((HOLD_ON_AFULL != 0) & bus.fifo_almost_full);

  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      remaining   <= '0;
      pkt_count_q <= '0;
      start_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start && bus.pkt_len != '0) begin
        len_q     <= bus.pkt_len;
        remaining <= bus.pkt_len;
      end
      if (xfer) remaining <= remaining - 1'b1;
      if (state == DONE) pkt_count_q <= pkt_count_q + 1'b1;
      // A start outside IDLE is never queued; it only raises the sticky flag.
      if (state != IDLE && bus.start) start_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    w_en      = 1'b0;
    rdy       = 1'b0;
    din       = '0;
    case (state)
      IDLE: begin
        if (bus.start && bus.pkt_len != '0) state_nxt = HDR;
      end
      HDR: begin
        din  = DATA_W'(len_q);
        w_en = !stall;
        if (!stall) state_nxt = PAY;
      end
      PAY: begin
        rdy  = !stall;
        din  = bus.s_data;
        xfer = bus.s_valid & !stall;
        w_en = xfer;
        if (xfer && remaining == LEN_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.fifo_w_en = w_en;
  assign bus.fifo_din  = din;
  assign bus.s_ready   = rdy;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.start_err = start_err_q;
  assign bus.pkt_count = pkt_count_q;
  assign dbg_state     = state;
endmodule
